// File: rtl/wait_state_memory.sv
// -----------------------------------------------------------------------------
// wait_state_memory
//
// Single-port synchronous RAM behind a request/acknowledge handshake. Each
// accepted request is stretched by WAIT_CYCLES wait states before the access
// completes with a one-cycle ack pulse. Out-of-range addresses and requests
// that assert both strobes are rejected with err during the ack cycle.
//
// Parameters:
//   DATA_W       word width in bits
//   ADDR_W       address width in bits
//   DEPTH        implemented words, 1 <= DEPTH <= 2**ADDR_W
//   WAIT_CYCLES  wait states per access, 0..15
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset (array contents are kept)
//   w, r     write / read strobes, sampled only while ready=1
//   address  word address, captured when a request is accepted
//   dataIn   write data, captured when a request is accepted
//   dataOut  registered read data, holds the last successful read
//   ready    idle and able to accept a request
//   ack      one-cycle completion pulse
//   err      request rejected; meaningful only while ack=1
// -----------------------------------------------------------------------------
module wait_state_memory #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w,
  input  logic              r,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              ready,
  output logic              ack,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0]      CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  state_t              state, next_state;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                cmd_w_q, cmd_r_q;
  logic                err_q;

  logic                accept, enter_resp;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_data;
  logic                acc_w, acc_r, acc_bad;
  logic                do_write, do_read;

  logic [DATA_W-1:0]   mem [DEPTH];

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (w || r) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            next_state = S_RESP;
            enter_resp = 1'b1;
          end else begin
            next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          next_state = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge itself,
  // before the latches hold the request, so the live inputs are used then.
  always_comb begin
    acc_addr = accept ? address : addr_q;
    acc_data = accept ? dataIn  : data_q;
    acc_w    = accept ? w       : cmd_w_q;
    acc_r    = accept ? r       : cmd_r_q;
  end

  assign acc_bad  = ({1'b0, acc_addr} >= DEPTH_L) || (acc_w && acc_r);
  assign do_write = enter_resp && !acc_bad && acc_w;
  assign do_read  = enter_resp && !acc_bad && acc_r;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      data_q  <= '0;
      cmd_w_q <= 1'b0;
      cmd_r_q <= 1'b0;
      err_q   <= 1'b0;
      dataOut <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        addr_q  <= address;
        data_q  <= dataIn;
        cmd_w_q <= w;
        cmd_r_q <= r;
        cnt     <= CNT_INIT;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) err_q <= acc_bad;
      if (do_read)    dataOut <= mem[acc_addr];
    end
  end

  // NOTE: the array has no reset so it maps onto plain RAM; rst only gates the
  // write strobe so an aborted access never reaches the array.
  always_ff @(posedge clk) begin
    if (do_write && !rst) mem[acc_addr] <= acc_data;
  end

  assign ready = (state == S_IDLE);
  assign ack   = (state == S_RESP);
  assign err   = (state == S_RESP) && err_q;

endmodule

// File: tb/tb_wait_state_memory.sv
// -----------------------------------------------------------------------------
// tb_wait_state_memory
//
// Two instances share the clock: u_slow (WAIT_CYCLES=2) and u_fast
// (WAIT_CYCLES=0), both DEPTH=12. Requests push their expected completion
// (err, dataOut, completion edge) into a per-instance queue; a monitor pops
// and compares on every ack. The reference model is a plain word array.
// -----------------------------------------------------------------------------
module tb_wait_state_memory;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DP = 12;

  typedef struct {
    logic          err;
    logic [DW-1:0] dout;
    int            done_edge;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_s   [2];
  logic          w_s     [2];
  logic          r_s     [2];
  logic [AW-1:0] addr_s  [2];
  logic [DW-1:0] din_s   [2];
  logic [DW-1:0] dout_s  [2];
  logic          ready_s [2];
  logic          ack_s   [2];
  logic          err_s   [2];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t q_slow[$];
  exp_t q_fast[$];

  logic [DW-1:0] ref_mem  [2][DP];
  logic [DW-1:0] ref_dout [2];
  logic          prev_ack [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wait_state_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .WAIT_CYCLES(2)) u_slow (
    .clk(clk), .rst(rst_s[0]), .w(w_s[0]), .r(r_s[0]), .address(addr_s[0]),
    .dataIn(din_s[0]), .dataOut(dout_s[0]), .ready(ready_s[0]), .ack(ack_s[0]),
    .err(err_s[0]));

  wait_state_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .WAIT_CYCLES(0)) u_fast (
    .clk(clk), .rst(rst_s[1]), .w(w_s[1]), .r(r_s[1]), .address(addr_s[1]),
    .dataIn(din_s[1]), .dataOut(dout_s[1]), .ready(ready_s[1]), .ack(ack_s[1]),
    .err(err_s[1]));

  function automatic int waits_of(input int id);
    return (id == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of one request: returns what the ack cycle must show.
  function automatic exp_t model(input int id, input logic wr, input logic rd,
                                 input int a, input logic [DW-1:0] d, input int acc_edge);
    exp_t e;
    logic bad;
    bad = (a >= DP) || (wr && rd);
    if (!bad && wr) ref_mem[id][a] = d;
    if (!bad && rd) ref_dout[id] = ref_mem[id][a];
    e.err       = bad;
    e.dout      = ref_dout[id];
    e.done_edge = acc_edge + waits_of(id);
    return e;
  endfunction

  task automatic push(input int id, input exp_t e);
    if (id == 0) q_slow.push_back(e);
    else         q_fast.push_back(e);
  endtask

  task automatic wait_ready(input int id);
    int n = 0;
    @(negedge clk);
    while (!ready_s[id] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_s[id]) check("ready_timeout", 32'(ready_s[id]), 32'd1);
  endtask

  // Issues one request; after acceptance the bus is scrambled so a design that
  // uses live inputs instead of the captured request is caught.
  task automatic issue(input int id, input logic wr, input logic rd,
                       input int a, input logic [DW-1:0] d);
    wait_ready(id);
    w_s[id]    = wr;
    r_s[id]    = rd;
    addr_s[id] = AW'(a);
    din_s[id]  = d;
    @(posedge clk);
    #1;
    push(id, model(id, wr, rd, a, d, cyc));
    w_s[id]    = 1'b0;
    r_s[id]    = 1'b0;
    addr_s[id] = AW'($urandom_range(0, 15));
    din_s[id]  = DW'($urandom);
  endtask

  // Monitor: every ack is matched against the next scoreboard entry.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ack_s[k] === 1'b1) begin
        exp_t e;
        logic empty;
        empty = (k == 0) ? (q_slow.size() == 0) : (q_fast.size() == 0);
        check("ack_single_pulse", 32'(prev_ack[k]), 32'd0);
        check("ack_expected", 32'(empty), 32'd0);
        if (!empty) begin
          e = (k == 0) ? q_slow.pop_front() : q_fast.pop_front();
          check("ack_latency", 32'(cyc), 32'(e.done_edge));
          check("err", 32'(err_s[k]), 32'(e.err));
          check("dataOut", 32'(dout_s[k]), 32'(e.dout));
          check("ready_low_in_ack", 32'(ready_s[k]), 32'd0);
        end
      end
      prev_ack[k] = ack_s[k];
    end
  end

  task automatic check_idle(input int id, input string tag);
    check({tag, "_ready"}, 32'(ready_s[id]), 32'd1);
    check({tag, "_ack"},   32'(ack_s[id]),   32'd0);
    check({tag, "_err"},   32'(err_s[id]),   32'd0);
    check({tag, "_dout"},  32'(dout_s[id]),  32'd0);
  endtask

  task automatic random_ops(input int id, input int n);
    for (int a = 0; a < DP; a++) issue(id, 1'b1, 1'b0, a, DW'($urandom));
    for (int i = 0; i < n; i++) begin
      int op;
      op = $urandom_range(0, 9);
      issue(id, op <= 4, (op == 0) || (op > 4), $urandom_range(0, 15), DW'($urandom));
    end
  endtask

  initial begin
    exp_t e;
    int   s;
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b1; w_s[k] = 1'b0; r_s[k] = 1'b0;
      addr_s[k] = '0; din_s[k] = '0; ref_dout[k] = '0; prev_ack[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_idle(0, "reset_slow");
    check_idle(1, "reset_fast");
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;

    // Directed sequence on the two-wait-state instance.
    issue(0, 1'b1, 1'b0, 3, 8'h03);
    issue(0, 1'b0, 1'b1, 3, 8'h00);
    issue(0, 1'b1, 1'b0, 7, 8'h07);
    issue(0, 1'b0, 1'b1, 7, 8'h00);
    issue(0, 1'b0, 1'b1, 12, 8'h00);
    issue(0, 1'b1, 1'b0, 15, 8'h99);
    issue(0, 1'b0, 1'b1, 3, 8'h00);
    issue(0, 1'b1, 1'b1, 3, 8'hAA);
    issue(0, 1'b0, 1'b1, 3, 8'h00);

    // Held read strobe: acceptances every 4 cycles, 3 within 12 edges.
    wait_ready(0);
    r_s[0] = 1'b1;
    addr_s[0] = 4'd3;
    s = cyc + 1;
    for (int i = 0; i < 3; i++) push(0, model(0, 1'b0, 1'b1, 3, 8'h00, s + 4 * i));
    repeat (12) @(posedge clk);
    #1 r_s[0] = 1'b0;

    // Reset during WAIT aborts the write of 8'h55.
    wait_ready(0);
    w_s[0] = 1'b1; addr_s[0] = 4'd3; din_s[0] = 8'h55;
    @(posedge clk);
    #1 w_s[0] = 1'b0;
    @(negedge clk);
    rst_s[0] = 1'b1;
    ref_dout[0] = '0;
    @(negedge clk);
    rst_s[0] = 1'b0;
    #2 check_idle(0, "abort");
    issue(0, 1'b0, 1'b1, 3, 8'h00);

    // Zero-wait-state instance: ack directly after acceptance.
    issue(1, 1'b1, 1'b0, 3, 8'h03);
    issue(1, 1'b0, 1'b1, 3, 8'h00);
    issue(1, 1'b0, 1'b1, 13, 8'h00);
    issue(1, 1'b1, 1'b1, 3, 8'hAA);
    issue(1, 1'b0, 1'b1, 3, 8'h00);

    random_ops(0, 60);
    random_ops(1, 60);

    for (int n = 0; n < 100 && (q_slow.size() + q_fast.size()) != 0; n++) @(negedge clk);
    check("scoreboard_drained", 32'(q_slow.size() + q_fast.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wait_state_memory.md
# wait_state_memory

Parametrised single-port synchronous RAM with a request/acknowledge handshake, a configurable number of wait states, and range/command error reporting. It succeeds the fixed 16x8 `w`/`r` memory. It serves as the CPU's data and instruction store, so the control unit can model slow memory by stalling on `ready`/`ack`.

## Interface
Parameters:
- `DATA_W`, default 8: word width in bits.
- `ADDR_W`, default 4: address width in bits.
- `DEPTH`, default 16: number of words implemented. Must satisfy 1 <= `DEPTH` <= 2^`ADDR_W`.
- `WAIT_CYCLES`, default 1: wait states inserted per access. Range 0..15.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `w`, in, 1: write strobe, sampled only when `ready`=1.
- `r`, in, 1: read strobe, sampled only when `ready`=1.
- `address`, in, `ADDR_W`: word address, captured at request acceptance.
- `dataIn`, in, `DATA_W`: write data, captured at request acceptance.
- `dataOut`, out, `DATA_W`: registered read data; holds the last successful read.
- `ready`, out, 1: controller idle and able to accept a request.
- `ack`, out, 1: one-cycle pulse marking access completion.
- `err`, out, 1: valid only while `ack`=1; set when the request was rejected.

## Operation
FSM states:
- IDLE: `ready`=1, `ack`=0.
- WAIT: `ready`=0, `ack`=0. A 4-bit counter `cnt` is active.
- RESP: `ready`=0, `ack`=1.

Acceptance and transitions:
- A request is accepted on a rising edge when the state is IDLE, `rst`=0, and (`w`|`r`)=1.
- On acceptance, `address`, `dataIn`, and the command are latched. The latched values, not the live inputs, drive the access.
- IDLE -> WAIT with `cnt`=`WAIT_CYCLES`-1 if `WAIT_CYCLES`>0. Otherwise IDLE -> RESP directly.
- In WAIT, `cnt` decrements each edge; at `cnt`=0 the FSM moves WAIT -> RESP.
- RESP -> IDLE unconditionally on the next edge. Strobes during WAIT or RESP are ignored, not queued.

The access is performed on the edge that enters RESP:
- Valid write: mem[addr] <= data. `dataOut` is unchanged.
- Valid read: `dataOut` <= mem[addr].

Error cases, all with `err`=1 in RESP and no array write and no `dataOut` change:
- Latched address >= `DEPTH`.
- `w` and `r` both 1 at acceptance.

Reset and storage:
- Array contents are not cleared by `rst`.
- Reset values: state IDLE, `ready`=1, `ack`=0, `err`=0, `dataOut`=0, `cnt`=0, latches 0.
- `rst` asserted mid-operation (WAIT or RESP) aborts the access; no array write occurs if `rst` rises before the RESP-entry edge. On `rst` release, the FSM is in IDLE.
- Address arithmetic is unsigned. There is no wrap-around: out-of-range addresses are errors, not aliases.

## Timing
- Acceptance edge E0. `ack` is high for exactly the one cycle after edge E0+`WAIT_CYCLES`.
- `ready` is low from after E0 through the `ack` cycle, and returns high the cycle after `ack`.
- Minimum spacing between accepted requests is `WAIT_CYCLES`+2 cycles.
- Read data is valid on `dataOut` in the `ack` cycle and holds until the next successful read or reset.
- Read after write to the same address returns the new data. The write completes at its RESP-entry edge, before any later acceptance.
- `ready`, `ack`, and `err` are decoded from registered state only; there is no combinational path from inputs.

## Test plan
Bench configuration: `DATA_W`=8, `ADDR_W`=4, `DEPTH`=12, `WAIT_CYCLES`=2.
- Reset, then write `address`=3, `dataIn`=8'h03: `ack`=1 exactly 3 cycles after the accept edge, `err`=0, `dataOut` stays 8'h00. A follow-up read of address 3 gives `dataOut`=8'h03 in its `ack` cycle.
- Write 8'h07 to address 7; change `dataIn` to 8'hFF during WAIT; then read address 7: `dataOut`=8'h07. This confirms the captured data was used.
- Read address 12 (>= `DEPTH`): `ack`=1 with `err`=1, and `dataOut` keeps its previous value 8'h07. A write to address 15 also gives `err`=1, and a subsequent read of address 3 still returns 8'h03.
- Assert `w`=`r`=1 at address 3 with `dataIn`=8'hAA: `err`=1. A subsequent read of address 3 returns 8'h03.
- Hold `r`=1 continuously on address 3: acceptances are exactly 4 cycles apart, `ack` is a single-cycle pulse each time, and there is no acceptance while `ready`=0.
- Start a write of 8'h55 to address 3 and pulse `rst` during WAIT: after release, the FSM is in IDLE with `ack`=`err`=0 and `dataOut`=8'h00. A read of address 3 returns 8'h03, proving the write was aborted. Repeat with `WAIT_CYCLES`=0: `ack` arrives in the cycle immediately after acceptance.
